// File: rtl/store_commit_drainer.sv
// Drains committed stores from the store-queue head into the L1 D-cache write
// port, one at a time in program order, retrying the same payload after a miss.
module store_commit_drainer #(
  parameter int  ENTRY_NUM    = 16,
  parameter int  COMMIT_WIDTH = 2,
  parameter int  ADDR_W       = 32,
  parameter int  DATA_W       = 64,
  localparam int IDX_W        = $clog2(ENTRY_NUM),
  localparam int CNT_W        = $clog2(ENTRY_NUM) + 1,
  localparam int BE_W         = DATA_W / 8,
  localparam int COMMIT_W     = $clog2(COMMIT_WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COMMIT_W-1:0] commitStoreNum,
  input  logic [ADDR_W-1:0]   headAddr,
  input  logic [DATA_W-1:0]   headData,
  input  logic [BE_W-1:0]     headBE,
  input  logic                headCondEnabled,
  output logic [IDX_W-1:0]    retiredPtr,
  output logic                releaseHead,
  output logic                cacheWrReq,
  output logic [ADDR_W-1:0]   cacheWrAddr,
  output logic [DATA_W-1:0]   cacheWrData,
  output logic [BE_W-1:0]     cacheWrBE,
  input  logic                cacheWrAck,
  input  logic                cacheWrHit,
  input  logic                cacheRefillDone,
  output logic [CNT_W-1:0]    pendingCount,
  output logic                drained,
  output logic                overflowErr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    MISS_WAIT = 2'd2
  } drainStateT;

  localparam logic [CNT_W:0] PEND_CAP = (CNT_W + 1)'(ENTRY_NUM);

  drainStateT     state;
  logic           hasPending;
  logic           condFailRelease;
  logic           writeRelease;
  logic [CNT_W:0] pendingSum;

  // Only stores already counted before this edge may be released; a commit
  // landing this cycle is netted into the counter but cannot pop until next cycle.
  assign hasPending      = (pendingCount != '0);
  assign condFailRelease = (state == IDLE) && hasPending && !headCondEnabled;
  assign writeRelease    = (state == REQ) && hasPending && cacheWrAck && cacheWrHit;
  assign releaseHead     = condFailRelease || writeRelease;
  assign drained         = !hasPending && (state == IDLE);

  assign pendingSum = {1'b0, pendingCount}
                    + (CNT_W + 1)'(commitStoreNum)
                    - (CNT_W + 1)'(releaseHead);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      retiredPtr   <= '0;
      pendingCount <= '0;
      overflowErr  <= 1'b0;
      cacheWrReq   <= 1'b0;
      cacheWrAddr  <= '0;
      cacheWrData  <= '0;
      cacheWrBE    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of its neighbours, independent of statement order.
      if (releaseHead) begin
        retiredPtr <= retiredPtr + IDX_W'(1);
      end

      if (pendingSum > PEND_CAP) begin
        pendingCount <= PEND_CAP[CNT_W-1:0];
        overflowErr  <= 1'b1;
      end else begin
        pendingCount <= pendingSum[CNT_W-1:0];
      end

      unique case (state)
        IDLE: begin
          if (hasPending && headCondEnabled) begin
            cacheWrAddr <= headAddr;
            cacheWrData <= headData;
            cacheWrBE   <= headBE;
            cacheWrReq  <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (cacheWrAck) begin
            cacheWrReq <= 1'b0;
            state      <= cacheWrHit ? IDLE : MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          // Payload registers are left untouched so the retry reissues the
          // exact captured store without re-reading the queue head.
          if (cacheRefillDone) begin
            cacheWrReq <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          cacheWrReq <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_drainer.sv
// Table-driven bench for store_commit_drainer: each row drives one cycle of
// inputs and lists the hand-computed outputs expected in that same cycle.
module tb_store_commit_drainer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  commitStoreNum = '0;
  logic [31:0] headAddr;
  logic [63:0] headData;
  logic [7:0]  headBE;
  logic        headCondEnabled = 1'b0;
  logic [3:0]  retiredPtr;
  logic        releaseHead;
  logic        cacheWrReq;
  logic [31:0] cacheWrAddr;
  logic [63:0] cacheWrData;
  logic [7:0]  cacheWrBE;
  logic        cacheWrAck = 1'b0;
  logic        cacheWrHit = 1'b0;
  logic        cacheRefillDone = 1'b0;
  logic [4:0]  pendingCount;
  logic        drained;
  logic        overflowErr;
  logic [7:0]  salt = '0;

  store_commit_drainer dut (
    .clk             (clk),
    .rst             (rst),
    .commitStoreNum  (commitStoreNum),
    .headAddr        (headAddr),
    .headData        (headData),
    .headBE          (headBE),
    .headCondEnabled (headCondEnabled),
    .retiredPtr      (retiredPtr),
    .releaseHead     (releaseHead),
    .cacheWrReq      (cacheWrReq),
    .cacheWrAddr     (cacheWrAddr),
    .cacheWrData     (cacheWrData),
    .cacheWrBE       (cacheWrBE),
    .cacheWrAck      (cacheWrAck),
    .cacheWrHit      (cacheWrHit),
    .cacheRefillDone (cacheRefillDone),
    .pendingCount    (pendingCount),
    .drained         (drained),
    .overflowErr     (overflowErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addrOf(input logic [3:0] p);
    return 32'h8000_0000 | (32'(p) << 6);
  endfunction

  function automatic logic [63:0] dataOf(input logic [3:0] p, input logic [7:0] s);
    return 64'hC0DE_0000_0000_0000 | (64'(s) << 8) | 64'(p);
  endfunction

  function automatic logic [7:0] beOf(input logic [3:0] p);
    return {4'hA, p};
  endfunction

  // Store-queue model: combinational read at the DUT's head pointer; salt lets
  // a row change the head contents to prove the retry does not re-read it.
  always_comb begin
    headAddr = addrOf(retiredPtr);
    headData = dataOf(retiredPtr, salt);
    headBE   = beOf(retiredPtr);
  end

  typedef struct {
    logic [1:0] commit;
    logic       cond, ack, hit, refill;
    logic [7:0] salt;
    logic       rel, req;
    logic [4:0] pend;
    logic [3:0] ptr;
    logic       drn, ovf;
    logic [7:0] pSalt;
    logic       rstPulse;
  } vecT;

  vecT vecs[$];
  int  nChecks = 0;
  int  nPass   = 0;

  task automatic r(input int c, cd, a, h, rf, s, rel, req, pend, ptr, drn, ovf, ps, rp);
    vecT v;
    v.commit = 2'(c);   v.cond = 1'(cd);  v.ack = 1'(a);   v.hit = 1'(h);
    v.refill = 1'(rf);  v.salt = 8'(s);   v.rel = 1'(rel); v.req = 1'(req);
    v.pend = 5'(pend);  v.ptr = 4'(ptr);  v.drn = 1'(drn); v.ovf = 1'(ovf);
    v.pSalt = 8'(ps);   v.rstPulse = 1'(rp);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  task automatic checkReset(input int row);
    check("rst.releaseHead",  row, 64'(releaseHead),  64'd0);
    check("rst.cacheWrReq",   row, 64'(cacheWrReq),   64'd0);
    check("rst.pendingCount", row, 64'(pendingCount), 64'd0);
    check("rst.retiredPtr",   row, 64'(retiredPtr),   64'd0);
    check("rst.drained",      row, 64'(drained),      64'd1);
    check("rst.overflowErr",  row, 64'(overflowErr),  64'd0);
    check("rst.cacheWrAddr",  row, 64'(cacheWrAddr),  64'd0);
    check("rst.cacheWrData",  row, cacheWrData,       64'd0);
    check("rst.cacheWrBE",    row, 64'(cacheWrBE),    64'd0);
  endtask

  initial begin
    // Basic hit: capture in IDLE, request+ack+hit next cycle, drained after.
    r(1,1,0,0,0,0,    0,0,0,0,1,0,0,0);
    r(0,1,0,0,0,0,    0,0,1,0,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,1,0,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,0,1,1,0,0,0);
    // Miss path: stray refill and hit-without-ack ignored, refill 5 cycles after miss.
    r(1,1,0,0,1,0,    0,0,0,1,1,0,0,0);
    r(0,1,0,0,0,0,    0,0,1,1,0,0,0,0);
    r(0,1,0,1,0,0,    0,1,1,1,0,0,0,0);
    r(0,1,1,0,0,0,    0,1,1,1,0,0,0,0);
    for (int k = 0; k < 4; k++) r(0,1,0,0,0,8'h5A, 0,0,1,1,0,0,0,0);
    r(0,1,0,0,1,8'h5A, 0,0,1,1,0,0,0,0);
    r(0,1,1,1,0,8'h5A, 1,1,1,1,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,0,2,1,0,0,0);
    // Failed conditional stores: three back-to-back releases, no cache request.
    r(2,0,0,0,0,0,    0,0,0,2,1,0,0,0);
    r(1,0,0,0,0,0,    1,0,2,2,0,0,0,0);
    r(0,0,0,0,0,0,    1,0,2,3,0,0,0,0);
    r(0,0,0,0,0,0,    1,0,1,4,0,0,0,0);
    r(0,0,0,0,0,0,    0,0,0,5,1,0,0,0);
    // Advance the pointer to 14 with commit-and-release in the same cycle.
    r(1,0,0,0,0,0,    0,0,0,5,1,0,0,0);
    for (int k = 1; k <= 8; k++) r(1,0,0,0,0,0, 1,0,1,4+k,0,0,0,0);
    r(0,0,0,0,0,0,    1,0,1,13,0,0,0,0);
    // Wrap 14->15->0->1 with commits overlapping drains.
    r(2,1,1,1,0,0,    0,0,0,14,1,0,0,0);
    r(2,1,1,1,0,0,    0,0,2,14,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,4,14,0,0,0,0);
    r(0,1,1,1,0,0,    0,0,3,15,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,3,15,0,0,0,0);
    r(0,1,1,1,0,0,    0,0,2,0,0,0,0,0);
    r(1,1,1,1,0,0,    1,1,2,0,0,0,0,0);
    r(0,1,1,1,0,0,    0,0,2,1,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,2,1,0,0,0,0);
    r(0,1,1,1,0,0,    0,0,1,2,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,1,2,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,0,3,1,0,0,0);
    // Overflow: 17 commits with no ack, saturate at 16, sticky error, reset in REQ.
    r(2,1,0,0,0,0,    0,0,0,3,1,0,0,0);
    r(2,1,0,0,0,0,    0,0,2,3,0,0,0,0);
    for (int k = 2; k <= 7; k++) r(2,1,0,0,0,0, 0,1,2*k,3,0,0,0,0);
    r(1,1,0,0,0,0,    0,1,16,3,0,0,0,0);
    r(0,1,0,0,0,0,    0,1,16,3,0,1,0,0);
    r(2,1,0,0,0,0,    0,1,16,3,0,1,0,0);
    r(0,1,0,0,0,0,    0,1,16,3,0,1,0,1);
    // Reset while in MISS_WAIT, then stray refill in IDLE, then a clean hit.
    r(1,0,0,0,0,0,    0,0,0,0,1,0,0,0);
    r(1,0,0,0,0,0,    1,0,1,0,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,1,1,0,0,0,0);
    r(0,1,1,0,0,0,    0,1,1,1,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,1,1,0,0,0,1);
    r(0,1,0,0,1,0,    0,0,0,0,1,0,0,0);
    r(1,1,0,0,0,0,    0,0,0,0,1,0,0,0);
    r(0,1,0,0,0,0,    0,0,1,0,0,0,0,0);
    r(0,1,1,1,0,0,    1,1,1,0,0,0,0,0);
    r(0,1,0,0,0,0,    0,0,0,1,1,0,0,0);

    repeat (2) @(negedge clk);
    #1;
    checkReset(-1);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      commitStoreNum  = vecs[i].commit;
      headCondEnabled = vecs[i].cond;
      cacheWrAck      = vecs[i].ack;
      cacheWrHit      = vecs[i].hit;
      cacheRefillDone = vecs[i].refill;
      salt            = vecs[i].salt;
      #1;
      check("releaseHead",  i, 64'(releaseHead),  64'(vecs[i].rel));
      check("cacheWrReq",   i, 64'(cacheWrReq),   64'(vecs[i].req));
      check("pendingCount", i, 64'(pendingCount), 64'(vecs[i].pend));
      check("retiredPtr",   i, 64'(retiredPtr),   64'(vecs[i].ptr));
      check("drained",      i, 64'(drained),      64'(vecs[i].drn));
      check("overflowErr",  i, 64'(overflowErr),  64'(vecs[i].ovf));
      if (vecs[i].req) begin
        check("cacheWrAddr", i, 64'(cacheWrAddr), 64'(addrOf(vecs[i].ptr)));
        check("cacheWrData", i, cacheWrData,      dataOf(vecs[i].ptr, vecs[i].pSalt));
        check("cacheWrBE",   i, 64'(cacheWrBE),   64'(beOf(vecs[i].ptr)));
      end
      if (vecs[i].rstPulse) begin
        rst = 1'b0;
        #1;
        checkReset(i);
        commitStoreNum  = '0;
        cacheWrAck      = 1'b0;
        cacheWrHit      = 1'b0;
        cacheRefillDone = 1'b0;
        salt            = '0;
        rst = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
